aes_rkey_sched: RTL and testbench

Round-key scheduler and store for the AES-128 core. It sequences `aes_key_gen` through all key-expansion rounds, driving its round controls and round constant. It captures each round key from `key_o` into an (NR+1)-entry buffer and serves any round key to the cipher datapath through a registered read port, for both encryption order and decryption (reverse) order.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_rkey_sched_if.sv | 13 +
 rtl/aes_rkey_ram.sv | 46 ++++
 rtl/aes_rkey_sched.sv | 129 ++++++++++++
 tb/tb_aes_rkey_sched.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types and helpers used by the round-key scheduler.
package aes_pkg;

  typedef logic [7:0]   ByteType;
  typedef logic [31:0]  aes_word;
  typedef logic [127:0] key_128;

  localparam int      AES_NR    = 10;
  localparam ByteType RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_WAIT,
    ST_DONE
  } rks_state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic ByteType xtime(ByteType r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rkey_sched_if.sv
// Round-key read port between the cipher datapath (master) and the scheduler (slave).
interface aes_rkey_sched_if;
  import aes_pkg::*;

  logic       rk_rd;
  logic [3:0] rk_idx;
  logic       rk_valid;
  key_128     rk_data;

  modport master (output rk_rd, output rk_idx, input rk_valid, input rk_data);
  modport slave  (input rk_rd, input rk_idx, output rk_valid, output rk_data);

endinterface

// File: rtl/aes_rkey_ram.sv
// (NR+1) x 128 round-key store: one write port, one registered read port.
module aes_rkey_ram
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       we,
  input  logic [3:0] waddr,
  input  key_128     wdata,
  input  logic       re,
  input  logic [3:0] raddr,
  output logic       rvalid,
  output key_128     rdata
);

  key_128 mem_q [NR+1];
  logic   rvalid_d, rvalid_q;
  key_128 rdata_d, rdata_q;

  // Storage carries no reset; contents are only meaningful once all keys are written.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rvalid_d = re;
    rdata_d  = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: rtl/aes_rkey_sched.sv
// AES-128 round-key scheduler: steps aes_key_gen through NR rounds and serves the stored keys.
module aes_rkey_sched
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int KG_LAT = 2
) (
  input  logic   clk,
  input  logic   nrst,
  input  logic   start,
  input  key_128 cipher_key,
  output logic   busy,
  output logic   keys_ready,
  output logic   kg_en,
  output logic   kg_gen_key,
  output logic   kg_next_rnd,
  output ByteType kg_rcon,
  output key_128 kg_key_i,
  input  key_128 kg_key_o,
  aes_rkey_sched_if.slave rd
);

  localparam logic [3:0] NR_IDX    = 4'(NR);
  localparam logic [3:0] WCNT_LAST = 4'(KG_LAT - 1);
  localparam logic [3:0] RND_FIRST = 4'd1;

  rks_state_e state_d, state_q;
  logic [3:0] rnd_d, rnd_q;
  logic [3:0] wcnt_d, wcnt_q;
  ByteType    rcon_d, rcon_q;
  key_128     key_i_d, key_i_q;

  logic       we;
  logic [3:0] waddr;
  key_128     wdata;
  logic       rd_en;

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    wcnt_d      = wcnt_q;
    rcon_d      = rcon_q;
    key_i_d     = key_i_q;
    we          = 1'b0;
    waddr       = '0;
    wdata       = kg_key_o;
    busy        = 1'b0;
    keys_ready  = 1'b0;
    kg_gen_key  = 1'b0;
    kg_next_rnd = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        keys_ready = (state_q == ST_DONE);
        if (start) begin
          we      = 1'b1;
          waddr   = '0;
          wdata   = cipher_key;
          key_i_d = cipher_key;
          rnd_d   = RND_FIRST;
          rcon_d  = RCON_INIT;
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        busy        = 1'b1;
        kg_gen_key  = (rnd_q == RND_FIRST);
        kg_next_rnd = (rnd_q != RND_FIRST);
        wcnt_d      = '0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        busy   = 1'b1;
        wcnt_d = wcnt_q + 4'd1;
        // The key generator output is valid only in the last wait cycle of the round.
        if (wcnt_q == WCNT_LAST) begin
          we      = 1'b1;
          waddr   = rnd_q;
          wdata   = kg_key_o;
          key_i_d = kg_key_o;
          if (rnd_q == NR_IDX) begin
            state_d = ST_DONE;
          end else begin
            rnd_d   = rnd_q + 4'd1;
            rcon_d  = xtime(rcon_q);
            state_d = ST_GEN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      wcnt_q  <= '0;
      rcon_q  <= '0;
      key_i_q <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      wcnt_q  <= wcnt_d;
      rcon_q  <= rcon_d;
      key_i_q <= key_i_d;
    end
  end

  assign kg_en    = busy;
  assign kg_rcon  = rcon_q;
  assign kg_key_i = key_i_q;

  // A read in the same cycle as a restart still sees the old buffer contents.
  assign rd_en = rd.rk_rd && keys_ready && (rd.rk_idx <= NR_IDX);

  aes_rkey_ram #(.NR(NR)) u_ram (
    .clk    (clk),
    .nrst   (nrst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re     (rd_en),
    .raddr  (rd.rk_idx),
    .rvalid (rd.rk_valid),
    .rdata  (rd.rk_data)
  );

endmodule

// File: tb/tb_aes_rkey_sched.sv
// Bench for aes_rkey_sched: behavioural aes_key_gen model plus a FIPS-197 key-expansion reference.
module tb_aes_rkey_sched;
  import aes_pkg::*;

  logic    clk = 1'b0;
  logic    nrst, start;
  key_128  cipher_key;
  logic    busy, keys_ready, kg_en, kg_gen_key, kg_next_rnd;
  ByteType kg_rcon;
  key_128  kg_key_i, kg_key_o;

  aes_rkey_sched_if rif ();

  aes_rkey_sched #(.NR(10), .KG_LAT(2)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .cipher_key  (cipher_key),
    .busy        (busy),
    .keys_ready  (keys_ready),
    .kg_en       (kg_en),
    .kg_gen_key  (kg_gen_key),
    .kg_next_rnd (kg_next_rnd),
    .kg_rcon     (kg_rcon),
    .kg_key_i    (kg_key_i),
    .kg_key_o    (kg_key_o),
    .rd          (rif)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  logic [7:0] sbox_t [256];
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  key_128 ref_k [11];
  key_128 last_data;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] b, int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(logic [7:0] x);
    logic [7:0] r = 8'h01;
    if (x == 8'h00) r = 8'h00;
    else for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic key_128 expand(key_128 k, logic [7:0] rc);
    logic [31:0] w0 = k[127:96];
    logic [31:0] w1 = k[95:64];
    logic [31:0] w2 = k[63:32];
    logic [31:0] w3 = k[31:0];
    logic [31:0] t, n0, n1, n2, n3;
    t  = subw({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // aes_key_gen stand-in: result appears KG_LAT=2 cycles after a load/next pulse.
  key_128 kg_s1;
  always @(posedge clk) begin
    if (!nrst) begin
      kg_s1    <= '0;
      kg_key_o <= '0;
    end else begin
      if (kg_gen_key || kg_next_rnd) kg_s1 <= expand(kg_key_i, kg_rcon);
      kg_key_o <= kg_s1;
    end
  end

  logic [7:0] rcon_seen [$];
  int gk_cnt = 0, nx_cnt = 0, both_cnt = 0, gk_pos = -1;
  always @(negedge clk) begin
    if (nrst) begin
      if (kg_gen_key && kg_next_rnd) both_cnt++;
      if (kg_gen_key) begin
        gk_cnt++;
        gk_pos = rcon_seen.size();
      end
      if (kg_next_rnd) nx_cnt++;
      if (kg_gen_key || kg_next_rnd) rcon_seen.push_back(kg_rcon);
    end
  end

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_ref(key_128 k);
    ref_k[0] = k;
    for (int r = 1; r <= 10; r++) ref_k[r] = expand(ref_k[r-1], rcon_tab[r-1]);
  endtask

  task automatic chk_rst(string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".keys_ready"}, keys_ready, 0);
    chk({tag, ".kg_en"}, kg_en, 0);
    chk({tag, ".kg_gen_key"}, kg_gen_key, 0);
    chk({tag, ".kg_next_rnd"}, kg_next_rnd, 0);
    chk({tag, ".rk_valid"}, rif.rk_valid, 0);
    chk({tag, ".kg_rcon"}, kg_rcon, 0);
    chk({tag, ".kg_key_i"}, kg_key_i, 0);
    chk({tag, ".rk_data"}, rif.rk_data, 0);
  endtask

  // Called in cycle 1 (first GEN); returns the cycle index in which keys_ready is seen.
  task automatic wait_ready(input int inj, output int lat);
    lat = 1;
    while (!keys_ready && lat < 100) begin
      if (lat == inj) begin
        chk("busy_at_inject", busy, 1);
        start      = 1'b1;
        cipher_key = ~cipher_key;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic run(string tag, key_128 k, int inj);
    int lat;
    build_ref(k);
    start      = 1'b1;
    cipher_key = k;
    tick();
    start = 1'b0;
    wait_ready(inj, lat);
    chk({tag, ".ready_cycle"}, lat, 31);
  endtask

  task automatic read_all(string tag);
    rif.rk_rd  = 1'b1;
    rif.rk_idx = 4'd0;
    for (int i = 0; i <= 10; i++) begin
      tick();
      chk($sformatf("%s.valid%0d", tag, i), rif.rk_valid, 1);
      chk($sformatf("%s.rk%0d", tag, i), rif.rk_data, ref_k[i]);
      if (i < 10) rif.rk_idx = 4'(i + 1);
      else rif.rk_rd = 1'b0;
    end
    tick();
    chk({tag, ".valid_after"}, rif.rk_valid, 0);
    last_data = ref_k[10];
  endtask

  task automatic rand_reads(string tag, int n);
    logic       rdv, expv;
    logic [3:0] idx;
    for (int i = 0; i < n; i++) begin
      rdv        = 1'($urandom_range(0, 1));
      idx        = 4'($urandom_range(0, 15));
      rif.rk_rd  = rdv;
      rif.rk_idx = idx;
      expv       = rdv && (idx <= 4'd10);
      if (expv) last_data = ref_k[idx];
      tick();
      chk($sformatf("%s.v%0d_idx%0d", tag, i, idx), rif.rk_valid, expv);
      chk($sformatf("%s.d%0d_idx%0d", tag, i, idx), rif.rk_data, last_data);
    end
    rif.rk_rd = 1'b0;
  endtask

  initial begin
    int     base, gk0, nx0, lat;
    key_128 k;
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

    nrst       = 1'b0;
    start      = 1'b0;
    cipher_key = '0;
    rif.rk_rd  = 1'b0;
    rif.rk_idx = 4'd0;
    repeat (3) tick();
    chk_rst("reset");
    nrst = 1'b1;
    tick();

    // FIPS-197 key, with an extra start during round-4 WAIT that must be ignored.
    base = rcon_seen.size();
    gk0  = gk_cnt;
    nx0  = nx_cnt;
    run("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c, 11);
    chk("done.busy", busy, 0);
    chk("done.kg_en", kg_en, 0);
    chk("rcon.count", rcon_seen.size() - base, 10);
    for (int i = 0; i < 10; i++)
      if (base + i < rcon_seen.size())
        chk($sformatf("rcon%0d", i), rcon_seen[base+i], rcon_tab[i]);
    chk("gen_key.count", gk_cnt - gk0, 1);
    chk("gen_key.round", gk_pos, base);
    chk("next_rnd.count", nx_cnt - nx0, 9);
    chk("pulse_overlap", both_cnt, 0);

    rif.rk_rd  = 1'b1;
    rif.rk_idx = 4'd10;
    chk("rd.no_early_valid", rif.rk_valid, 0);
    tick();
    rif.rk_idx = 4'd0;
    chk("rd10.valid", rif.rk_valid, 1);
    chk("rd10.fips", rif.rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    rif.rk_idx = 4'd5;
    chk("rd0.valid", rif.rk_valid, 1);
    chk("rd0.data", rif.rk_data, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    tick();
    rif.rk_idx = 4'd1;
    chk("rd5.valid", rif.rk_valid, 1);
    chk("rd5.data", rif.rk_data, ref_k[5]);
    tick();
    rif.rk_idx = 4'd11;
    chk("rd1.valid", rif.rk_valid, 1);
    chk("rd1.fips", rif.rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
    tick();
    rif.rk_rd = 1'b0;
    chk("rd11.valid", rif.rk_valid, 0);
    chk("rd11.hold", rif.rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
    read_all("fips");

    // Reset asserted in cycle 12 of an expansion.
    start      = 1'b1;
    cipher_key = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start = 1'b0;
    repeat (11) tick();
    nrst = 1'b0;
    tick();
    chk_rst("midrst");
    nrst = 1'b1;
    run("after_rst", {$urandom, $urandom, $urandom, $urandom}, -1);
    read_all("after_rst");

    // Restart from DONE with a simultaneous read of the old rk[10].
    k          = ref_k[10];
    start      = 1'b1;
    cipher_key = 128'h000102030405060708090a0b0c0d0e0f;
    rif.rk_rd  = 1'b1;
    rif.rk_idx = 4'd10;
    tick();
    start     = 1'b0;
    rif.rk_rd = 1'b0;
    chk("restart.keys_ready", keys_ready, 0);
    chk("restart.busy", busy, 1);
    chk("restart.rd_valid", rif.rk_valid, 1);
    chk("restart.rd_old", rif.rk_data, k);
    build_ref(128'h000102030405060708090a0b0c0d0e0f);
    wait_ready(-1, lat);
    chk("restart.ready_cycle", lat, 31);
    rif.rk_rd  = 1'b1;
    rif.rk_idx = 4'd10;
    tick();
    rif.rk_rd = 1'b0;
    chk("restart.rk10", rif.rk_data, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    read_all("restart");

    for (int t = 0; t < 3; t++) begin
      run($sformatf("rand%0d", t), {$urandom, $urandom, $urandom, $urandom}, -1);
      rand_reads($sformatf("rand%0d", t), 16);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
